exc_ctrl: RTL
=============

Name: exc_ctrl

Overview:
- Exception/ERET sequencer between the MEM stage and CP0.
- Collects per-instruction exception flags and the CP0 interrupt request, prioritises them, and issues the single-cycle MEM_Exc/ExcCode/eret_flush strobes that CP0 consumes.
- Flushes the pipeline, waits for any outstanding data-bus transaction to finish, then hands a redirect PC (exception vector or EPC) to fetch over a valid/ready handshake.

Parameters:
EXC_VECTOR, 32'hBFC00380, general exception entry PC
PC_W, 32, PC/address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
mem_valid  in  1  MEM stage holds a real instruction this cycle
mem_pc  in  32  PC of MEM instruction
mem_bd  in  1  MEM instruction is in a branch delay slot
mem_addr  in  32  MEM load/store effective address
int_req  in  1  CP0 Interrupt output
exc_adel_if  in  1  fetch address error
exc_ri  in  1  reserved instruction
exc_ov  in  1  integer overflow
exc_sys  in  1  syscall
exc_bp  in  1  break
exc_adel_d  in  1  load address error
exc_ades  in  1  store address error
is_eret  in  1  MEM instruction is ERET
epc_in  in  32  CP0 EPC_out
bus_busy  in  1  data bus transaction outstanding
redirect_ready  in  1  fetch accepts redirect
MEM_Exc  out  1  exception strobe to CP0
MEM_ExcCode  out  5  exception code to CP0
MEM_badvaddr  out  32  faulting address to CP0
MEM_bd_o  out  1  mem_bd forwarded to CP0
MEM_eret_flush  out  1  ERET strobe to CP0
flush  out  1  kill IF..MEM, block MEM writes
redirect_valid  out  1  redirect PC valid
redirect_pc  out  32  new fetch PC

Behaviour:
- States: IDLE, WAIT_BUS, REDIRECT.
- Reset (async, rst=0): state=IDLE, redirect_valid=0, redirect_pc=0. All strobes are 0 because they are gated by IDLE and mem_valid.
- take = mem_valid && state==IDLE.
- exc_any = int_req | any exc_* flag.
- Priority, highest first, with ExcCode:
  - int_req: 5'h00
  - exc_adel_if: 5'h04
  - exc_ri: 5'h0A
  - exc_ov: 5'h0C
  - exc_sys: 5'h08
  - exc_bp: 5'h09
  - exc_adel_d: 5'h04
  - exc_ades: 5'h05
- Combinational outputs, valid in the same cycle as the MEM instruction:
  - MEM_Exc = take & exc_any.
  - MEM_ExcCode = code of the winning cause.
  - MEM_badvaddr = mem_pc for exc_adel_if; mem_addr for exc_adel_d/exc_ades; 0 otherwise.
  - MEM_eret_flush = take & is_eret & ~exc_any. Exception wins over ERET, including an interrupt on the ERET itself.
  - MEM_bd_o = mem_bd.
  - flush = (take & (exc_any | is_eret)) | (state != IDLE).
- Target PC: EXC_VECTOR for an exception; epc_in for ERET, sampled in the strobe cycle.
- Transitions:
  - IDLE to WAIT_BUS on an event with bus_busy=1. The target is latched into redirect_pc.
  - IDLE to REDIRECT on an event with bus_busy=0. redirect_pc is latched and redirect_valid=1 from the next cycle.
  - WAIT_BUS to REDIRECT on the first cycle bus_busy=0. redirect_valid rises the next cycle.
  - REDIRECT: redirect_valid and redirect_pc are held stable until redirect_valid & redirect_ready. On that cycle: return to IDLE, redirect_valid=0 at the next edge.
- Minimum latency: strobe in cycle N, redirect_valid in N+1, IDLE in N+2 if ready is held high.
- While not IDLE: no new strobes, mem_valid ignored, and int_req is not sampled. A pending interrupt is taken on the first valid instruction after return to IDLE.
- Single-cycle strobes: each event produces exactly one MEM_Exc or MEM_eret_flush pulse. No duplicate strobe if MEM stalls with mem_valid high, because the state has left IDLE.
- rst asserted in WAIT_BUS/REDIRECT: immediately IDLE, redirect_valid=0.

Decomposition:
- Shared package/define file (alongside the existing macro defines): ExcCode constants Int, AdEL, AdES, Sys, Bp, RI, Ov, plus the state encodings.
- One natural sub-module, exc_prio: purely combinational priority encoder producing exc_any, code, and badvaddr-select.
- FSM and redirect register live in exc_ctrl.

Test Plan:
- mem_valid=1, exc_ov=1, bus_busy=0, redirect_ready=1 at N+1:
  - Cycle N: MEM_Exc=1, MEM_ExcCode=5'h0C, flush=1.
  - N+1: redirect_valid=1, redirect_pc=32'hBFC00380.
  - N+2: IDLE, redirect_valid=0.
- int_req=1 with exc_ri=1, mem_pc=32'hBFC00100 -> MEM_ExcCode=5'h00, MEM_badvaddr=0.
- exc_adel_d=1, mem_addr=32'h80000003 -> MEM_ExcCode=5'h04, MEM_badvaddr=32'h80000003.
- exc_adel_if=1, mem_pc=32'h80000002 -> MEM_ExcCode=5'h04, MEM_badvaddr=32'h80000002.
- is_eret=1, epc_in=32'hBFC00200, bus_busy=1 for 3 cycles, redirect_ready low 2 cycles:
  - MEM_eret_flush pulses once.
  - Stays in WAIT_BUS 3 cycles with flush=1.
  - redirect_pc=32'hBFC00200 held until ready.
  - Then IDLE; no second strobe while mem_valid stays 1.
- is_eret=1 with exc_bp=1 -> MEM_Exc=1 with code 5'h09, MEM_eret_flush=0.
- rst pulsed low in REDIRECT -> redirect_valid=0 immediately, next valid exception strobes normally.

Source files
------------

// File: rtl/exc_ctrl_pkg.sv
// Shared ExcCode constants, sequencer state encoding and cause-flag bundle.
// No logic; combinational helpers only.
// Imported by exc_prio and exc_ctrl.
package exc_ctrl_pkg;

  // CP0 Cause.ExcCode values for the causes this block can raise
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_BUS = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  // Which source feeds BadVAddr for the winning cause
  typedef enum logic [1:0] {
    BVA_NONE = 2'd0,
    BVA_PC   = 2'd1,
    BVA_ADDR = 2'd2
  } bva_sel_t;

  // Raw cause flags, most significant field is highest priority
  typedef struct packed {
    logic int_req;
    logic adel_if;
    logic ri;
    logic ov;
    logic sys;
    logic bp;
    logic adel_d;
    logic ades;
  } exc_flags_t;

endpackage

// File: rtl/exc_prio.sv
// Priority encoder: picks the winning exception cause, its ExcCode and BadVAddr source.
// Latency: purely combinational.
// Backpressure: none; outputs are a pure function of the flags.
module exc_prio
  import exc_ctrl_pkg::*;
(
  input  exc_flags_t flags,
  output logic       exc_any,
  output logic [4:0] code,
  output bva_sel_t   bva_sel
);

  // Any cause at all, including a pending interrupt
  assign exc_any = |flags;

  // Fixed-priority select: interrupt first, then fetch-side, decode, execute, memory causes
  always_comb begin
    code    = EXC_INT;
    bva_sel = BVA_NONE;
    if (flags.int_req) begin
      code    = EXC_INT;
      bva_sel = BVA_NONE;
    end else if (flags.adel_if) begin
      code    = EXC_ADEL;
      bva_sel = BVA_PC;
    end else if (flags.ri) begin
      code    = EXC_RI;
    end else if (flags.ov) begin
      code    = EXC_OV;
    end else if (flags.sys) begin
      code    = EXC_SYS;
    end else if (flags.bp) begin
      code    = EXC_BP;
    end else if (flags.adel_d) begin
      code    = EXC_ADEL;
      bva_sel = BVA_ADDR;
    end else if (flags.ades) begin
      code    = EXC_ADES;
      bva_sel = BVA_ADDR;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/ERET sequencer: strobes CP0, flushes the pipe, waits out the data bus, redirects fetch.
// Latency: CP0 strobes combinational with the MEM instruction; redirect_valid one cycle later at best.
// Backpressure: redirect held stable until redirect_ready; flush held high the whole time.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_valid,
  input  logic [PC_W-1:0] mem_pc,
  input  logic            mem_bd,
  input  logic [PC_W-1:0] mem_addr,
  input  logic            int_req,
  input  logic            exc_adel_if,
  input  logic            exc_ri,
  input  logic            exc_ov,
  input  logic            exc_sys,
  input  logic            exc_bp,
  input  logic            exc_adel_d,
  input  logic            exc_ades,
  input  logic            is_eret,
  input  logic [PC_W-1:0] epc_in,
  input  logic            bus_busy,
  input  logic            redirect_ready,
  output logic            MEM_Exc,
  output logic [4:0]      MEM_ExcCode,
  output logic [PC_W-1:0] MEM_badvaddr,
  output logic            MEM_bd_o,
  output logic            MEM_eret_flush,
  output logic            flush,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc
);

  state_t          state;
  exc_flags_t      flags;
  logic            exc_any;
  logic [4:0]      code;
  bva_sel_t        bva_sel;
  logic            take;
  logic            event_hit;
  logic [PC_W-1:0] target_pc;

  assign flags = '{
    int_req: int_req,
    adel_if: exc_adel_if,
    ri:      exc_ri,
    ov:      exc_ov,
    sys:     exc_sys,
    bp:      exc_bp,
    adel_d:  exc_adel_d,
    ades:    exc_ades
  };

  exc_prio u_prio (
    .flags   (flags),
    .exc_any (exc_any),
    .code    (code),
    .bva_sel (bva_sel)
  );

  // Only an IDLE sequencer accepts a MEM instruction; this also keeps a
  // stalled MEM instruction from strobing CP0 twice.
  assign take      = mem_valid && (state == ST_IDLE);
  assign event_hit = take && (exc_any || is_eret);

  // Exceptions (including an interrupt on an ERET) go to the vector, ERET to EPC
  assign target_pc = exc_any ? EXC_VECTOR : epc_in;

  assign MEM_Exc        = take && exc_any;
  assign MEM_eret_flush = take && is_eret && !exc_any;
  assign MEM_ExcCode    = code;
  assign MEM_bd_o       = mem_bd;
  assign flush          = event_hit || (state != ST_IDLE);

  // BadVAddr source follows the winning cause
  always_comb begin
    MEM_badvaddr = '0;
    case (bva_sel)
      BVA_PC:   MEM_badvaddr = mem_pc;
      BVA_ADDR: MEM_badvaddr = mem_addr;
      default:  MEM_badvaddr = '0;
    endcase
  end

  // Sequencer FSM with registered redirect handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (event_hit) begin
            redirect_pc <= target_pc;
            if (bus_busy) begin
              state <= ST_WAIT_BUS;
            end else begin
              state          <= ST_REDIRECT;
              redirect_valid <= 1'b1;
            end
          end
        end
        ST_WAIT_BUS: begin
          // Target already latched; just wait for the bus to drain
          if (!bus_busy) begin
            state          <= ST_REDIRECT;
            redirect_valid <= 1'b1;
          end
        end
        ST_REDIRECT: begin
          if (redirect_ready) begin
            state          <= ST_IDLE;
            redirect_valid <= 1'b0;
          end
        end
        default: begin
          state          <= ST_IDLE;
          redirect_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
